// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - command/response port and APB bus bundle for apb_master
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Command side
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  // Response side: one-cycle strobe, no backpressure
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  // APB bus
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB initiator bridging a valid/ready command port to APB transfers; optional ACCESS timeout under APB_MASTER_TIMEOUT_EN
module apb_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef APB_MASTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input logic          PCLK,
  input logic          PRESETn,
  apb_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] paddr, paddr_nxt;
  logic [DATA_W-1:0] pwdata, pwdata_nxt;
  logic              pwrite, pwrite_nxt;
  logic [DATA_W-1:0] rdata, rdata_nxt;

`ifdef APB_MASTER_TIMEOUT_EN
  // Counter only ever reaches TIMEOUT_CYCLES-1 before the abort fires
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic             tmo_hit;
  logic             err, err_nxt;

  // This ACCESS cycle is the TIMEOUT_CYCLES-th one without PREADY
  assign tmo_hit = ((int'(tmo_cnt) + 1) == TIMEOUT_CYCLES);
`endif

  // State and bus/response registers; reset drops the bus to idle at once
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      paddr   <= '0;
      pwdata  <= '0;
      pwrite  <= 1'b0;
      rdata   <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt <= '0;
      err     <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      paddr   <= paddr_nxt;
      pwdata  <= pwdata_nxt;
      pwrite  <= pwrite_nxt;
      rdata   <= rdata_nxt;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt <= tmo_cnt_nxt;
      err     <= err_nxt;
`endif
    end
  end

  // Next-state and register updates for IDLE -> SETUP -> ACCESS -> DONE
  always_comb begin
    state_nxt   = state;
    paddr_nxt   = paddr;
    pwdata_nxt  = pwdata;
    pwrite_nxt  = pwrite;
    rdata_nxt   = rdata;
`ifdef APB_MASTER_TIMEOUT_EN
    tmo_cnt_nxt = tmo_cnt;
    err_nxt     = err;
`endif
    case (state)
      IDLE: begin
        // Command fields are captured only on the accept edge
        if (bus.cmd_valid) begin
          paddr_nxt  = bus.cmd_addr;
          pwdata_nxt = bus.cmd_wdata;
          pwrite_nxt = bus.cmd_write;
          state_nxt  = SETUP;
        end
      end
      SETUP: begin
`ifdef APB_MASTER_TIMEOUT_EN
        tmo_cnt_nxt = '0;
`endif
        state_nxt = ACCESS;
      end
      ACCESS: begin
        // A responder completing on the timeout edge still wins
        if (bus.PREADY) begin
          if (!pwrite) begin
            rdata_nxt = bus.PRDATA;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          err_nxt = 1'b0;
`endif
          state_nxt = DONE;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (tmo_hit) begin
          err_nxt   = 1'b1;
          rdata_nxt = '0;
          state_nxt = DONE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
        end
`endif
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Handshake and APB control decode straight from the state register
  assign bus.cmd_ready = (state == IDLE);
  assign bus.PSEL      = (state == SETUP) || (state == ACCESS);
  assign bus.PENABLE   = (state == ACCESS);
  assign bus.rsp_valid = (state == DONE);

  assign bus.PADDR     = paddr;
  assign bus.PWDATA    = pwdata;
  assign bus.PWRITE    = pwrite;
  assign bus.rsp_rdata = rdata;

`ifdef APB_MASTER_TIMEOUT_EN
  assign bus.rsp_err   = err;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master against a transaction-level model
module tb_apb_master;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TMO = 4;
`endif

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master #(
    .ADDR_W(AW),
    .DATA_W(DW)
`ifdef APB_MASTER_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int tmo_cycles = 0;
  // Model state: value rsp_rdata must show (last read data, 0 after reset/abort)
  logic [31:0] exp_rdata = '0;

  // Free-running edge counter for latency measurement
  always @(posedge PCLK) cyc <= cyc + 1;

  // One full command: waits for acceptance, plays responder, checks every cycle
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] rd, input bit keep, input bit tmo,
                         output int t_acc);
    int k;
    int n_acc;
    int lat;
    logic ready_now;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    k = 0;
    while (bus.cmd_ready !== 1'b1 && k < 20) begin
      @(negedge PCLK);
      k++;
    end
    n_cmp++;
    if (k >= 20) begin
      n_bad++;
      $display("FAIL accept_wait: cmd_ready=%b after %0d cycles, want 1", bus.cmd_ready, k);
    end
    @(negedge PCLK);
    t_acc = cyc;
    n_acc = tmo ? tmo_cycles : waits + 1;
    // SETUP cycle: PREADY/PRDATA and new commands must be ignored
    bus.cmd_valid = keep ? 1'b1 : 1'($urandom % 2);
    bus.cmd_write = 1'($urandom % 2);
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
    n_cmp++;
    if ({bus.PSEL, bus.PENABLE, bus.cmd_ready, bus.rsp_valid} !== 4'b1000) begin
      n_bad++;
      $display("FAIL setup_ctrl: psel/pen/rdy/rsp=%b want 1000", {bus.PSEL, bus.PENABLE, bus.cmd_ready, bus.rsp_valid});
    end
    n_cmp++;
    if ({bus.PADDR, bus.PWRITE, bus.PWDATA} !== {addr, wr, wdata}) begin
      n_bad++;
      $display("FAIL setup_bus: addr=%h wr=%b wdata=%h want %h %b %h", bus.PADDR, bus.PWRITE, bus.PWDATA, addr, wr, wdata);
    end
    bus.PREADY = 1'($urandom % 2);
    bus.PRDATA = $urandom;
    @(negedge PCLK);
    // ACCESS cycles
    for (int i = 0; i < n_acc; i++) begin
      n_cmp++;
      if ({bus.PSEL, bus.PENABLE, bus.cmd_ready, bus.rsp_valid} !== 4'b1100) begin
        n_bad++;
        $display("FAIL access_ctrl[%0d]: psel/pen/rdy/rsp=%b want 1100", i, {bus.PSEL, bus.PENABLE, bus.cmd_ready, bus.rsp_valid});
      end
      n_cmp++;
      if ({bus.PADDR, bus.PWRITE, bus.PWDATA} !== {addr, wr, wdata}) begin
        n_bad++;
        $display("FAIL access_bus[%0d]: addr=%h wr=%b wdata=%h want %h %b %h", i, bus.PADDR, bus.PWRITE, bus.PWDATA, addr, wr, wdata);
      end
      bus.cmd_valid = keep ? 1'b1 : 1'($urandom % 2);
      bus.cmd_addr  = $urandom;
      bus.cmd_wdata = $urandom;
      ready_now     = !tmo && (i == n_acc - 1);
      bus.PREADY    = ready_now;
      bus.PRDATA    = ready_now ? rd : $urandom;
      @(negedge PCLK);
    end
    // DONE cycle
    if (tmo) exp_rdata = '0;
    else if (!wr) exp_rdata = rd;
    lat = cyc - t_acc;
    n_cmp++;
    if ({bus.PSEL, bus.PENABLE, bus.cmd_ready, bus.rsp_valid} !== 4'b0001) begin
      n_bad++;
      $display("FAIL done_ctrl: psel/pen/rdy/rsp=%b want 0001", {bus.PSEL, bus.PENABLE, bus.cmd_ready, bus.rsp_valid});
    end
    n_cmp++;
    if (lat != n_acc + 1) begin
      n_bad++;
      $display("FAIL rsp_latency: %0d edges after accept, want %0d", lat, n_acc + 1);
    end
    n_cmp++;
    if (bus.rsp_err !== tmo) begin
      n_bad++;
      $display("FAIL rsp_err: got %b want %b", bus.rsp_err, tmo);
    end
    n_cmp++;
    if (bus.rsp_rdata !== exp_rdata) begin
      n_bad++;
      $display("FAIL rsp_rdata: got %h want %h", bus.rsp_rdata, exp_rdata);
    end
    bus.PREADY    = 1'($urandom % 2);
    bus.PRDATA    = $urandom;
    bus.cmd_valid = keep;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = '0;
    PRESETn       = 1'b0;
    repeat (2) @(negedge PCLK);
    n_cmp++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: psel/pen/pwrite/rsp/err=%b want 00000", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err});
    end
    n_cmp++;
    if ({bus.PADDR, bus.PWDATA, bus.rsp_rdata} !== 96'b0) begin
      n_bad++;
      $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h want 0", bus.PADDR, bus.PWDATA, bus.rsp_rdata);
    end
    PRESETn = 1'b1;
    @(negedge PCLK);
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_idle_ready: got %b want 1", bus.cmd_ready);
    end
  endtask

  task automatic test_write();
    int t;
    do_xfer(1'b1, 32'h08, 32'h55, 0, 32'h0, 1'b0, 1'b0, t);
    // Bus idles with address/data held; no spurious response
    repeat (3) begin
      @(negedge PCLK);
      n_cmp++;
      if ({bus.PSEL, bus.rsp_valid, bus.PADDR, bus.PWDATA} !== {2'b00, 32'h08, 32'h55}) begin
        n_bad++;
        $display("FAIL write_hold: psel=%b rsp=%b paddr=%h pwdata=%h want 0 0 08 55", bus.PSEL, bus.rsp_valid, bus.PADDR, bus.PWDATA);
      end
    end
  endtask

  task automatic test_read_wait();
    int t;
    do_xfer(1'b0, 32'h0C, $urandom, 2, 32'hA5, 1'b0, 1'b0, t);
    @(negedge PCLK);
    n_cmp++;
    if (bus.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL read_strobe_width: rsp_valid=%b want 0", bus.rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1, t2;
    do_xfer(1'b1, 32'h100, 32'h1111_0001, 0, 32'h0, 1'b1, 1'b0, t0);
    do_xfer(1'b0, 32'h104, 32'h2222_0002, 0, 32'hBEEF_0002, 1'b1, 1'b0, t1);
    do_xfer(1'b1, 32'h108, 32'h3333_0003, 0, 32'h0, 1'b0, 1'b0, t2);
    n_cmp++;
    if (t1 - t0 != 4 || t2 - t1 != 4) begin
      n_bad++;
      $display("FAIL b2b_spacing: %0d,%0d edges want 4,4", t1 - t0, t2 - t1);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h40;
    bus.cmd_wdata = 32'h0;
    bus.PREADY    = 1'b0;
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge PCLK);
    #2 PRESETn = 1'b0;
    #1;
    n_cmp++;
    if ({bus.PSEL, bus.PENABLE} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_mid_async: psel/pen=%b want 00", {bus.PSEL, bus.PENABLE});
    end
    exp_rdata = '0;
    repeat (3) begin
      @(negedge PCLK);
      n_cmp++;
      if (bus.rsp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_mid_rsp: rsp_valid=%b want 0", bus.rsp_valid);
      end
    end
    PRESETn = 1'b1;
    @(negedge PCLK);
    n_cmp++;
    if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_mid_after: rsp/rdy=%b want 01", {bus.rsp_valid, bus.cmd_ready});
    end
    do_xfer(1'b1, 32'h44, 32'h77, 1, 32'h0, 1'b0, 1'b0, t);
    do_xfer(1'b0, 32'h48, 32'h0, 0, 32'h1234_5678, 1'b0, 1'b0, t);
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int t;
    do_xfer(1'b0, 32'h20, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 1'b1, t);
    do_xfer(1'b0, 32'h24, 32'h0, TMO - 1, 32'hC0DE_0001, 1'b0, 1'b0, t);
  endtask
`else
  task automatic test_long_wait();
    int t;
    do_xfer(1'b0, 32'h30, 32'h0, 99, 32'h0F0F_A5A5, 1'b0, 1'b0, t);
  endtask
`endif

  task automatic test_random();
    int t;
    for (int n = 0; n < 20; n++) begin
      do_xfer(1'($urandom % 2), $urandom, $urandom, int'($urandom_range(0, 2)), $urandom,
              (n != 19) && ($urandom % 2 == 0), 1'b0, t);
    end
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
`ifdef APB_MASTER_TIMEOUT_EN
    tmo_cycles = TMO;
`endif
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_reset_mid();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_random();
    repeat (2) @(negedge PCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute guard so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 200000");
    $fatal(1);
  end
endmodule
